// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port between WB and an aux FIFO.
// Define STARVE_GUARD_EN to force a FIFO drain after MAX_WAIT cycles of waiting.
module regfile_write_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [4:0]  wb_dest,
    input  logic [31:0] wb_data,
    output logic        wb_stall,
    input  logic        aux_valid,
    input  logic [4:0]  aux_dest,
    input  logic [31:0] aux_data,
    output logic        aux_ready,
    input  logic [4:0]  src1,
    input  logic [4:0]  src2,
    output logic        src1_pending,
    output logic        src2_pending,
    output logic        rf_we,
    output logic [4:0]  rf_dest,
    output logic [31:0] rf_wdata
);
    localparam int AW = $clog2(DEPTH);

    logic [4:0]    dest_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          empty, full, wb_req, push, pop, grant_wb, starve;

    assign empty     = count == '0;
    assign full      = count == (AW+1)'(DEPTH);
    assign aux_ready = !rst && !full;
    assign wb_req    = wb_valid && wb_dest != 5'd0;
    assign push      = aux_valid && aux_ready && aux_dest != 5'd0;
    assign pop       = !empty && (!wb_req || starve);
    assign grant_wb  = wb_req && !starve;
    assign wb_stall  = wb_req && starve;

`ifdef STARVE_GUARD_EN
    localparam int SW = $clog2(MAX_WAIT + 1);
    logic [SW-1:0] wait_cnt;
    assign starve = wait_cnt == SW'(MAX_WAIT);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= '0;
        else if (empty || pop)
            wait_cnt <= '0;
        else if (!starve)
            wait_cnt <= wait_cnt + 1'b1;
    end
`else
    assign starve = 1'b0;
`endif

    // Payload storage needs no reset; validity is tracked by vld/count.
    always_ff @(posedge clk) begin
        if (push) begin
            dest_q[wr_ptr] <= aux_dest;
            data_q[wr_ptr] <= aux_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            vld      <= '0;
            rf_we    <= 1'b0;
            rf_dest  <= '0;
            rf_wdata <= '0;
        end else begin
            if (push) begin
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            rf_we <= pop || grant_wb;
            if (pop) begin
                rf_dest  <= dest_q[rd_ptr];
                rf_wdata <= data_q[rd_ptr];
            end else if (grant_wb) begin
                rf_dest  <= wb_dest;
                rf_wdata <= wb_data;
            end
        end
    end

    // The output stage commits at the next edge, so its dest still counts as pending.
    always_comb begin
        logic p1, p2;
        p1 = rf_we && rf_dest == src1;
        p2 = rf_we && rf_dest == src2;
        for (int i = 0; i < DEPTH; i++) begin
            p1 = p1 || (vld[i] && dest_q[i] == src1);
            p2 = p2 || (vld[i] && dest_q[i] == src2);
        end
        src1_pending = src1 != 5'd0 && p1;
        src2_pending = src2 != 5'd0 && p2;
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed checks of grant, FIFO order, pending flags and reset.
module tb_regfile_write_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid, aux_valid;
    logic [4:0]  wb_dest, aux_dest, src1, src2;
    logic [31:0] wb_data, aux_data;
    logic        wb_stall, aux_ready, src1_pending, src2_pending, rf_we;
    logic [4:0]  rf_dest;
    logic [31:0] rf_wdata;
    int          vecs = 0;
    int          errs = 0;

    regfile_write_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data), .wb_stall(wb_stall),
        .aux_valid(aux_valid), .aux_dest(aux_dest), .aux_data(aux_data), .aux_ready(aux_ready),
        .src1(src1), .src2(src2), .src1_pending(src1_pending), .src2_pending(src2_pending),
        .rf_we(rf_we), .rf_dest(rf_dest), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1; wb_valid = 0; wb_dest = 0; wb_data = 0;
        aux_valid = 0; aux_dest = 0; aux_data = 0; src1 = 0; src2 = 0;
        #1;
        chk("rst_aux_ready", aux_ready, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_dest", rf_dest, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_wb_stall", wb_stall, 0);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("post_rst_aux_ready", aux_ready, 1);

        // WB write appears one cycle later
        tick();
        wb_valid = 1; wb_dest = 5; wb_data = 32'h1234;
        tick();
        wb_valid = 0; src1 = 5;
        #1;
        chk("wb_rf_we", rf_we, 1);
        chk("wb_rf_dest", rf_dest, 5);
        chk("wb_rf_wdata", rf_wdata, 32'h1234);
        chk("wb_pending_out_stage", src1_pending, 1);
        src1 = 0;

        // dest 0 from either source is dropped
        wb_valid = 1; wb_dest = 0; wb_data = 32'h99;
        aux_valid = 1; aux_dest = 0; aux_data = 32'h77;
        tick();
        wb_valid = 0; aux_valid = 0;
        chk("wb0_rf_we", rf_we, 0);
        chk("wb0_rf_dest_hold", rf_dest, 5);
        chk("wb0_rf_wdata_hold", rf_wdata, 32'h1234);
        tick();
        chk("aux0_rf_we", rf_we, 0);

        // aux latency and pending window
        aux_valid = 1; aux_dest = 7; aux_data = 32'hAA; src1 = 7;
        #1;
        chk("aux_ready_idle", aux_ready, 1);
        chk("aux_pend_t", src1_pending, 0);
        tick();
        aux_valid = 0;
        #1;
        chk("aux_t1_rf_we", rf_we, 0);
        chk("aux_pend_t1", src1_pending, 1);
        tick();
        chk("aux_t2_rf_we", rf_we, 1);
        chk("aux_t2_rf_dest", rf_dest, 7);
        chk("aux_t2_rf_wdata", rf_wdata, 32'hAA);
        chk("aux_pend_t2", src1_pending, 1);
        tick();
        chk("aux_t3_rf_we", rf_we, 0);
        chk("aux_pend_t3", src1_pending, 0);
        src1 = 0;

        // fill FIFO behind busy WB, then offer a 5th while full
        for (int k = 0; k < 5; k++) begin
            wb_valid = 1; wb_dest = 5'(10 + k); wb_data = 32'h1000 + k;
            aux_valid = 1; aux_dest = (k < 4) ? 5'(k + 1) : 5'd9; aux_data = 32'hA0 + k + 1;
            #1;
            chk("fill_aux_ready", aux_ready, (k < 4) ? 1 : 0);
            if (k >= 1) chk("fill_wb_dest", rf_dest, 10 + k - 1);
            tick();
        end
        wb_valid = 0;
        src2 = 3;
        #1;
        chk("full_aux_ready_pop", aux_ready, 0);
        chk("full_rf_dest", rf_dest, 14);
        chk("full_src2_pending", src2_pending, 1);
        tick();
        aux_valid = 0; src2 = 0;
        #1;
        chk("drain_aux_ready", aux_ready, 1);
        for (int k = 1; k <= 4; k++) begin
            chk("drain_rf_we", rf_we, 1);
            chk("drain_rf_dest", rf_dest, k);
            chk("drain_rf_wdata", rf_wdata, 32'hA0 + k);
            tick();
        end
        chk("drain_done_rf_we", rf_we, 0);

        // simultaneous push/pop at count 2
        wb_valid = 1; wb_dest = 20; aux_valid = 1; aux_dest = 1; aux_data = 32'hB1;
        tick();
        wb_dest = 21; aux_dest = 2; aux_data = 32'hB2;
        #1;
        chk("pp_rf_dest20", rf_dest, 20);
        tick();
        wb_valid = 0; aux_dest = 3; aux_data = 32'hB3;
        #1;
        chk("pp_aux_ready", aux_ready, 1);
        chk("pp_rf_dest21", rf_dest, 21);
        tick();
        aux_valid = 0;
        for (int k = 1; k <= 3; k++) begin
            chk("pp_rf_dest", rf_dest, k);
            chk("pp_rf_wdata", rf_wdata, 32'hB0 + k);
            tick();
        end
        chk("pp_done_rf_we", rf_we, 0);

        // pointer wrap: 10 back-to-back aux results
        for (int k = 0; k < 12; k++) begin
            aux_valid = k < 10; aux_dest = 5'(k + 1); aux_data = 32'hC000 + k;
            tick();
            if (k >= 1 && k <= 10) begin
                chk("wrap_rf_we", rf_we, 1);
                chk("wrap_rf_dest", rf_dest, k);
                chk("wrap_rf_wdata", rf_wdata, 32'hC000 + k - 1);
            end
        end
        chk("wrap_done_rf_we", rf_we, 0);

        // reset with three queued entries
        for (int k = 0; k < 3; k++) begin
            wb_valid = 1; wb_dest = 20; wb_data = 32'h5;
            aux_valid = 1; aux_dest = 5'(11 + k); aux_data = 32'hD0 + k;
            tick();
        end
        aux_valid = 0;
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_rf_we", rf_we, 0);
        chk("mid_rst_rf_dest", rf_dest, 0);
        chk("mid_rst_rf_wdata", rf_wdata, 0);
        chk("mid_rst_aux_ready", aux_ready, 0);
        wb_valid = 0;
        tick(); tick();
        rst = 1'b0; src1 = 11;
        #1;
        chk("after_rst_aux_ready", aux_ready, 1);
        chk("after_rst_pending", src1_pending, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("after_rst_no_write", rf_we, 0);
        end
        src1 = 0;

        // starvation under continuous WB
        wb_valid = 1; wb_dest = 30; wb_data = 32'h100;
        aux_valid = 1; aux_dest = 6; aux_data = 32'h66;
        tick();
        aux_valid = 0;
        for (int j = 1; j <= 12; j++) begin
            #1;
`ifdef STARVE_GUARD_EN
            chk("starve_wb_stall", wb_stall, j == 9);
            chk("starve_rf_dest", rf_dest, (j == 10) ? 6 : 30);
`else
            chk("nostarve_wb_stall", wb_stall, 0);
            chk("nostarve_rf_dest", rf_dest, 30);
`endif
            tick();
        end
        wb_valid = 0;
        tick();
`ifdef STARVE_GUARD_EN
        chk("starve_end_rf_we", rf_we, 0);
`else
        chk("nostarve_end_rf_we", rf_we, 1);
        chk("nostarve_end_rf_dest", rf_dest, 6);
        chk("nostarve_end_rf_wdata", rf_wdata, 32'h66);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
